// File: rtl/hwpe_stream_tcdm_rr_arbiter_pkg.sv
// Shared TCDM constants and the request bundle type used by the
// round-robin arbiter and its response-index FIFO.
package hwpe_stream_package;

   localparam int unsigned HWPE_TCDM_ADDR_W = 32;
   localparam int unsigned HWPE_TCDM_BE_W   = 4;
   localparam int unsigned HWPE_TCDM_DATA_W = 32;

   // One TCDM request as seen on the shared slave port.
   typedef struct packed {
      logic [HWPE_TCDM_ADDR_W-1:0] add;
      logic                        wen;
      logic [HWPE_TCDM_BE_W-1:0]   be;
      logic [HWPE_TCDM_DATA_W-1:0] data;
   } tcdm_req_t;

endpackage : hwpe_stream_package

// File: rtl/hwpe_stream_tcdm_resp_fifo.sv
// Small circular FIFO holding the requester index of every granted read,
// so that in-order read responses can be routed back to their owner.
module hwpe_stream_tcdm_resp_fifo #(
   parameter int unsigned ID_W       = 2,
   parameter int unsigned RESP_DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            push_i,
   input  logic [ID_W-1:0] push_id_i,
   input  logic            pop_i,
   output logic            full_o,
   output logic            empty_o,
   output logic [ID_W-1:0] head_o
);

   localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

   logic [ID_W-1:0]  r_mem [RESP_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_cnt;

   logic w_push;
   logic w_pop;

   // Pointer increment with an explicit wrap so any depth works.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (r_cnt == CNT_W'(RESP_DEPTH));
   assign empty_o = (r_cnt == '0);
   assign head_o  = r_mem[r_rd_ptr];

   // A push into a full FIFO is only legal when the head leaves the same cycle.
   assign w_push = push_i & (~full_o | pop_i);
   assign w_pop  = pop_i & ~empty_o;

   // Storage write.
   // NOTE: the payload array has no reset; only pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_id_i;
      end
   end

   // Pointer and occupancy bookkeeping with synchronous reset.
   // NOTE: sequential state is updated only with non-blocking assignments.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule : hwpe_stream_tcdm_resp_fifo

// File: rtl/hwpe_stream_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM slave port among NB_IN masters.
// Reads are tracked in an index FIFO so responses may arrive with any
// latency of one cycle or more and still reach the right master.
module hwpe_stream_tcdm_rr_arbiter
   import hwpe_stream_package::*;
#(
   parameter int unsigned NB_IN      = 4,
   parameter int unsigned RESP_DEPTH = 2,
   parameter int unsigned ID_W       = $clog2(NB_IN)
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NB_IN-1:0]                    in_req_i,
   output logic [NB_IN-1:0]                    in_gnt_o,
   input  logic [NB_IN*HWPE_TCDM_ADDR_W-1:0]   in_add_i,
   input  logic [NB_IN-1:0]                    in_wen_i,
   input  logic [NB_IN*HWPE_TCDM_BE_W-1:0]     in_be_i,
   input  logic [NB_IN*HWPE_TCDM_DATA_W-1:0]   in_data_i,
   output logic [NB_IN*HWPE_TCDM_DATA_W-1:0]   in_r_data_o,
   output logic [NB_IN-1:0]                    in_r_valid_o,
   output logic                                out_req_o,
   input  logic                                out_gnt_i,
   output logic [HWPE_TCDM_ADDR_W-1:0]         out_add_o,
   output logic                                out_wen_o,
   output logic [HWPE_TCDM_BE_W-1:0]           out_be_o,
   output logic [HWPE_TCDM_DATA_W-1:0]         out_data_o,
   input  logic [HWPE_TCDM_DATA_W-1:0]         out_r_data_i,
   input  logic                                out_r_valid_i,
   output logic                                err_o
);

   logic [ID_W-1:0] r_ptr;
   logic            r_err;

   tcdm_req_t       w_fields [NB_IN];
   tcdm_req_t       w_sel;
   logic [NB_IN-1:0] w_elig;
   logic            w_found;
   logic [ID_W-1:0] w_win;
   logic            w_hs;
   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic [ID_W-1:0] w_head;

   // Unpack the flat per-requester buses into request bundles.
   always_comb begin
      for (int unsigned i = 0; i < NB_IN; i++) begin
         w_fields[i].add  = in_add_i [i*HWPE_TCDM_ADDR_W +: HWPE_TCDM_ADDR_W];
         w_fields[i].wen  = in_wen_i [i];
         w_fields[i].be   = in_be_i  [i*HWPE_TCDM_BE_W +: HWPE_TCDM_BE_W];
         w_fields[i].data = in_data_i[i*HWPE_TCDM_DATA_W +: HWPE_TCDM_DATA_W];
      end
   end

   // Reads are held back while the index FIFO is full; writes never are.
   // Nothing is eligible while reset is asserted.
   assign w_elig = in_req_i & ~(in_wen_i & {NB_IN{w_full}}) & {NB_IN{rst_ni}};

   // Priority search starting at the round-robin pointer.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      int unsigned idx;
      w_found = 1'b0;
      w_win   = '0;
      for (int unsigned k = 0; k < NB_IN; k++) begin
         idx = int'(r_ptr) + k;
         if (idx >= NB_IN) idx = idx - NB_IN;
         if (!w_found && w_elig[idx]) begin
            w_found = 1'b1;
            w_win   = ID_W'(idx);
         end
      end
   end

   // Field mux onto the shared port; idle port drives zeros.
   always_comb begin
      w_sel = '0;
      if (w_found) w_sel = w_fields[w_win];
   end

   assign out_req_o  = w_found;
   assign out_add_o  = w_sel.add;
   assign out_wen_o  = w_sel.wen;
   assign out_be_o   = w_sel.be;
   assign out_data_o = w_sel.data;

   assign w_hs   = out_req_o & out_gnt_i;
   assign w_push = w_hs & out_wen_o;
   assign w_pop  = out_r_valid_i & ~w_empty & rst_ni;

   // Grant goes straight back to the winner in the same cycle.
   always_comb begin
      in_gnt_o = '0;
      if (w_hs) in_gnt_o[w_win] = 1'b1;
   end

   // Route the response valid to the oldest outstanding reader.
   always_comb begin
      in_r_valid_o = '0;
      if (w_pop) in_r_valid_o[w_head] = 1'b1;
   end

   assign in_r_data_o = {NB_IN{out_r_data_i}};
   assign err_o       = r_err;

   hwpe_stream_tcdm_resp_fifo #(
      .ID_W       (ID_W),
      .RESP_DEPTH (RESP_DEPTH)
   ) i_resp_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push_i    (w_push),
      .push_id_i (w_win),
      .pop_i     (w_pop),
      .full_o    (w_full),
      .empty_o   (w_empty),
      .head_o    (w_head)
   );

   // Pointer advances past the winner only on a handshake; a stalled
   // winner keeps priority. The error flag is sticky until reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_ptr <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_hs) begin
            r_ptr <= (w_win == ID_W'(NB_IN - 1)) ? '0 : w_win + 1'b1;
         end
         if (out_r_valid_i && w_empty) begin
            r_err <= 1'b1;
         end
      end
   end

endmodule : hwpe_stream_tcdm_rr_arbiter
